// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event scheduler.
// Events are {repeat, ascii[7:0]}; timing defaults assume a 50 MHz clock.
package kbd_pkg;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_DELAY  = 2'd1,
    KS_REPEAT = 2'd2
  } kbd_state_e;

  localparam int KBD_EVT_W         = 9;
  localparam int CLK_HZ            = 50_000_000;
  localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF = CLK_HZ / 20;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry.
// The head register keeps the last popped entry once the FIFO runs empty.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = KBD_EVT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_q;
  logic [W-1:0]  head_q;
  logic          do_wr;
  logic          do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_next   = rd_ptr_q + 1'b1;
  assign rd_data_o = head_q;
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_wr && !rst_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_next;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // The new head is either the incoming word (FIFO effectively empty) or the next stored entry.
      if (do_wr && (empty_o || (do_rd && count_q == (AW+1)'(1)))) begin
        head_q <= wr_data_i;
      end else if (do_rd && count_q > (AW+1)'(1)) begin
        head_q <= mem_q[rd_next];
      end
    end
  end

endmodule

// File: rtl/kbd_event_scheduler.sv
// Queues ASCII keystrokes and generates typematic auto-repeat for a held key,
// delivering events to a consumer over a valid/ready handshake.
module kbd_event_scheduler
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   key_valid_i,
  input  logic                   key_is_ascii_i,
  input  logic [7:0]             key_ascii_i,
  input  logic [7:0]             key_scan_i,
  input  logic                   repeat_en_i,
  input  logic                   clear_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [7:0]             out_ascii_o,
  output logic                   out_repeat_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   overflow_o
);

  localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  kbd_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           rep_ascii_q, rep_ascii_d;
  logic [7:0]           rep_scan_q, rep_scan_d;
  logic                 overflow_q, overflow_d;
  logic                 tick;
  logic                 press;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [KBD_EVT_W-1:0] wr_data;
  logic [KBD_EVT_W-1:0] rd_data;

  assign press   = key_valid_i && key_is_ascii_i;
  assign wr_data = press ? {1'b0, key_ascii_i} : {1'b1, rep_ascii_q};

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .W     (KBD_EVT_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .wr_en_i   (press || tick),
    .wr_data_i (wr_data),
    .rd_en_i   (out_ready_i),
    .rd_data_o (rd_data),
    .count_o   (fifo_count_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid_o  = !fifo_empty;
  assign pop          = out_valid_o && out_ready_i;
  assign out_ascii_o  = rd_data[7:0];
  assign out_repeat_o = rd_data[8];
  assign overflow_o   = overflow_q;
  assign overflow_d   = overflow_q || (press && fifo_full && !pop);

  // A key press always restarts the repeat machine, so a tick due in the same cycle never fires.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_ascii_d = rep_ascii_q;
    rep_scan_d  = rep_scan_q;
    tick        = 1'b0;
    if (key_valid_i) begin
      cnt_d = '0;
      if (key_is_ascii_i && repeat_en_i) begin
        rep_ascii_d = key_ascii_i;
        rep_scan_d  = key_scan_i;
        state_d     = KS_DELAY;
      end else begin
        state_d = KS_IDLE;
      end
    end else if (state_q != KS_IDLE && (key_scan_i != rep_scan_q || !repeat_en_i)) begin
      state_d = KS_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        KS_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            tick    = 1'b1;
            cnt_d   = '0;
            state_d = KS_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        KS_REPEAT: begin
          if (cnt_q == PERIOD_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= KS_IDLE;
      cnt_q       <= '0;
      rep_ascii_q <= '0;
      rep_scan_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_ascii_q <= rep_ascii_d;
      rep_scan_q  <= rep_scan_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
